// File: rtl/mapache64_pkg.sv
// mapache64: shared types for the foreground line engine.
//  obm_object_t  32-bit OBM entry {x, y, pmfa, hflip, vflip, color, rsvd}
//  pixel_t       5-bit pixel {lightness, rgb}; lightness 0 means transparent
//  fg_state_t    engine states; EVAL and LOAD are the data-return cycles of SCAN and FETCH
package mapache64;
    localparam int FG_ROW_LEN = 8;
    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic [4:0] pmfa;
        logic       hflip;
        logic       vflip;
        logic [2:0] color;
        logic [5:0] rsvd;
    } obm_object_t;
    typedef struct packed {
        logic [1:0] lightness;
        logic [2:0] rgb;
    } pixel_t;
    typedef enum logic [2:0] {IDLE, CLEAR, SCAN, EVAL, FETCH, LOAD, DRAW, FINISH} fg_state_t;
endpackage

// File: rtl/foreground_line_engine_buffer.sv
// fg_line_buffer: one tagged foreground line buffer.
//  clk, rst_n          clock, asynchronous active-low reset
//  clear_i, clear_y_i  invalidate tag, zero pixel-valid vector, load new tag line
//  commit_i            mark the tag valid (line complete)
//  wr_en_i/wr_x_i/wr_pix_i  pixel write; ignored if the pixel is already valid
//  rd_x_i, rd_y_i      display read address
//  match_o             tag valid and equal to rd_y_i
//  rd_pix_o            pixel at rd_x_i, 0 when not yet written
module fg_line_buffer
    import mapache64::*;
#(
    parameter int LINE_WIDTH = 256,
    localparam int XW = $clog2(LINE_WIDTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear_i,
    input  logic [7:0]    clear_y_i,
    input  logic          commit_i,
    input  logic          wr_en_i,
    input  logic [XW-1:0] wr_x_i,
    input  pixel_t        wr_pix_i,
    input  logic [XW-1:0] rd_x_i,
    input  logic [7:0]    rd_y_i,
    output logic          match_o,
    output pixel_t        rd_pix_o
);
    logic [LINE_WIDTH-1:0] valid_q;
    pixel_t                mem_q [LINE_WIDTH];
    logic                  tag_valid_q;
    logic [7:0]            tag_y_q;
    logic                  wr_ok;

    // first writer of a pixel wins, giving lower object indices priority
    assign wr_ok = wr_en_i && !valid_q[wr_x_i];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= '0;
            tag_valid_q <= 1'b0;
            tag_y_q     <= '0;
        end else if (clear_i) begin
            valid_q     <= '0;
            tag_valid_q <= 1'b0;
            tag_y_q     <= clear_y_i;
        end else begin
            if (wr_ok) valid_q[wr_x_i] <= 1'b1;
            if (commit_i) tag_valid_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_x_i] <= wr_pix_i;
    end

    assign match_o  = tag_valid_q && tag_y_q == rd_y_i;
    assign rd_pix_o = valid_q[rd_x_i] ? mem_q[rd_x_i] : '0;
endmodule

// File: rtl/foreground_line_engine.sv
// foreground_line_engine: scans OBM for a scanline and renders hits into round-robin line buffers.
//  gpu_clk, rst_n                clock, asynchronous active-low reset
//  prefetch_start_i/_y_i         render request; busy_o, done_o, miss_o, overflow_o status
//  obm_addr_o/obm_object_i       OBM read port, data one cycle after address
//  pmf_addr_o/pmf_line_i         PMF read port, data one cycle after address
//  display_x_i/_y_i -> pixel_o/valid_o  registered display lookup, 1-cycle latency
//  FOREGROUND_LINE_ENGINE_DROPCOUNT_EN adds drop_count_o (objects skipped for the limit)
module foreground_line_engine
    import mapache64::*;
#(
    parameter int NUM_OBJECTS  = 64,
    parameter int NUM_LINES    = 2,
    parameter int MAX_PER_LINE = 16,
    parameter int LINE_WIDTH   = 256,
    localparam int OW = $clog2(NUM_OBJECTS),
    localparam int LW = $clog2(NUM_LINES),
    localparam int HW = $clog2(MAX_PER_LINE + 1),
    localparam int XW = $clog2(LINE_WIDTH)
) (
    input  logic          gpu_clk,
    input  logic          rst_n,
    input  logic          prefetch_start_i,
    input  logic [7:0]    prefetch_y_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          miss_o,
    output logic          overflow_o,
    output logic [OW-1:0] obm_addr_o,
    input  obm_object_t   obm_object_i,
    output logic [7:0]    pmf_addr_o,
    input  logic [15:0]   pmf_line_i,
    input  logic [7:0]    display_x_i,
    input  logic [7:0]    display_y_i,
    output pixel_t        pixel_o,
    output logic          valid_o
`ifdef FOREGROUND_LINE_ENGINE_DROPCOUNT_EN
    ,
    output logic [$clog2(NUM_OBJECTS+1)-1:0] drop_count_o
`endif
);
    fg_state_t      state_q, state_d;
    logic [7:0]     y_q, x_q, pmf_addr_q, dy;
    logic [LW-1:0]  rr_q, victim_q;
    logic [OW-1:0]  idx_q;
    logic [HW-1:0]  hits_q;
    logic           ovf_q, overflow_q, miss_q, hflip_q;
    logic [2:0]     color_q, k_q, col;
    logic [15:0]    line_q;
    pixel_t         pixel_q, disp_pix;
    logic           hit, at_limit, last, draw_en, unused_rsvd;
    logic [1:0]     lum;
    logic [8:0]     xs;
    logic [XW-1:0]  wr_x;
    logic [NUM_LINES-1:0] match;
    pixel_t         rd_pix [NUM_LINES];

    // 8-bit wrap-around distance from the object's top row
    assign dy          = y_q - obm_object_i.y;
    assign hit         = dy[7:3] == 5'd0;
    assign at_limit    = hits_q == HW'(MAX_PER_LINE);
    assign last        = idx_q == OW'(NUM_OBJECTS - 1);
    assign col         = k_q ^ {3{hflip_q}};
    assign lum         = 2'(line_q >> {~col, 1'b0});
    assign xs          = {1'b0, x_q} + {6'd0, k_q};
    assign wr_x        = XW'(xs >= 9'(LINE_WIDTH) ? xs - 9'(LINE_WIDTH) : xs);
    assign draw_en     = state_q == DRAW && lum != 2'd0;
    assign unused_rsvd = ^obm_object_i.rsvd;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = prefetch_start_i ? CLEAR : IDLE;
            CLEAR:   state_d = SCAN;
            SCAN:    state_d = EVAL;
            EVAL:    state_d = (hit && !at_limit) ? FETCH : last ? FINISH : SCAN;
            FETCH:   state_d = LOAD;
            LOAD:    state_d = DRAW;
            DRAW:    state_d = k_q != 3'd7 ? DRAW : last ? FINISH : SCAN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge gpu_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            y_q        <= '0;
            rr_q       <= '0;
            victim_q   <= '0;
            idx_q      <= '0;
            hits_q     <= '0;
            ovf_q      <= 1'b0;
            overflow_q <= 1'b0;
            miss_q     <= 1'b0;
            x_q        <= '0;
            pmf_addr_q <= '0;
            color_q    <= '0;
            hflip_q    <= 1'b0;
            k_q        <= '0;
            line_q     <= '0;
            pixel_q    <= '0;
        end else begin
            state_q <= state_d;
            miss_q  <= prefetch_start_i && state_q != IDLE;
            pixel_q <= disp_pix;
            if (state_q == IDLE && prefetch_start_i) begin
                y_q      <= prefetch_y_i;
                victim_q <= rr_q;
                rr_q     <= rr_q == LW'(NUM_LINES - 1) ? '0 : rr_q + 1'b1;
            end
            if (state_q == CLEAR) begin
                idx_q  <= '0;
                hits_q <= '0;
                ovf_q  <= 1'b0;
            end else if (state_d == SCAN) begin
                idx_q <= idx_q + 1'b1;
            end
            if (state_q == EVAL) begin
                x_q        <= obm_object_i.x;
                color_q    <= obm_object_i.color;
                hflip_q    <= obm_object_i.hflip;
                pmf_addr_q <= {obm_object_i.pmfa, dy[2:0] ^ {3{obm_object_i.vflip}}};
                if (hit && at_limit) ovf_q <= 1'b1;
                if (hit && !at_limit) hits_q <= hits_q + 1'b1;
            end
            if (state_q == LOAD) line_q <= pmf_line_i;
            k_q <= state_q == DRAW ? k_q + 1'b1 : '0;
            if (state_q == FINISH) overflow_q <= ovf_q;
        end
    end

`ifdef FOREGROUND_LINE_ENGINE_DROPCOUNT_EN
    logic [$clog2(NUM_OBJECTS+1)-1:0] drop_q, drop_count_q;
    always_ff @(posedge gpu_clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q       <= '0;
            drop_count_q <= '0;
        end else begin
            if (state_q == CLEAR) drop_q <= '0;
            else if (state_q == EVAL && hit && at_limit) drop_q <= drop_q + 1'b1;
            if (state_q == FINISH) drop_count_q <= drop_q;
        end
    end
    assign drop_count_o = drop_count_q;
`endif

    for (genvar g = 0; g < NUM_LINES; g++) begin : g_buf
        fg_line_buffer #(.LINE_WIDTH(LINE_WIDTH)) u_buf (
            .clk      (gpu_clk),
            .rst_n    (rst_n),
            .clear_i  (state_q == CLEAR && victim_q == LW'(g)),
            .clear_y_i(y_q),
            .commit_i (state_q == FINISH && victim_q == LW'(g)),
            .wr_en_i  (draw_en && victim_q == LW'(g)),
            .wr_x_i   (wr_x),
            .wr_pix_i (pixel_t'({lum, color_q})),
            .rd_x_i   (display_x_i[XW-1:0]),
            .rd_y_i   (display_y_i),
            .match_o  (match[g]),
            .rd_pix_o (rd_pix[g])
        );
    end

    // lowest-index matching buffer drives the display
    always_comb begin
        disp_pix = '0;
        for (int i = NUM_LINES - 1; i >= 0; i--) disp_pix = match[i] ? rd_pix[i] : disp_pix;
    end

    assign busy_o     = state_q != IDLE;
    assign done_o     = state_q == FINISH;
    assign miss_o     = miss_q;
    assign overflow_o = overflow_q;
    assign obm_addr_o = idx_q;
    assign pmf_addr_o = pmf_addr_q;
    assign pixel_o    = pixel_q;
    assign valid_o    = pixel_q.lightness != 2'd0;
endmodule

// File: tb/tb_foreground_line_engine.sv
// tb_foreground_line_engine: directed and randomized checks against a line-rendering reference model.
module tb_foreground_line_engine;
    import mapache64::*;
    localparam int NOBJ = 64, NL = 2, MAXL = 16;

    logic        gpu_clk = 1'b0, rst_n = 1'b1, prefetch_start_i = 1'b0;
    logic [7:0]  prefetch_y_i = '0, display_x_i = '0, display_y_i = '0, pmf_addr_o;
    logic        busy_o, done_o, miss_o, overflow_o, valid_o;
    logic [5:0]  obm_addr_o;
    obm_object_t obm_object_i;
    logic [15:0] pmf_line_i;
    pixel_t      pixel_o;
`ifdef FOREGROUND_LINE_ENGINE_DROPCOUNT_EN
    logic [6:0]  drop_count_o;
`endif

    foreground_line_engine dut (
        .gpu_clk(gpu_clk), .rst_n(rst_n), .prefetch_start_i(prefetch_start_i),
        .prefetch_y_i(prefetch_y_i), .busy_o(busy_o), .done_o(done_o), .miss_o(miss_o),
        .overflow_o(overflow_o), .obm_addr_o(obm_addr_o), .obm_object_i(obm_object_i),
        .pmf_addr_o(pmf_addr_o), .pmf_line_i(pmf_line_i), .display_x_i(display_x_i),
        .display_y_i(display_y_i), .pixel_o(pixel_o), .valid_o(valid_o)
`ifdef FOREGROUND_LINE_ENGINE_DROPCOUNT_EN
        , .drop_count_o(drop_count_o)
`endif
    );

    always #5 gpu_clk = ~gpu_clk;

    obm_object_t obm [NOBJ];
    logic [15:0] pmf [256];
    always @(posedge gpu_clk) begin
        obm_object_i <= obm[obm_addr_o];
        pmf_line_i   <= pmf[pmf_addr_o];
    end

    int checks = 0, errors = 0;
    logic [4:0] mdl_pix [NL][256];
    logic [7:0] mdl_tag [NL];
    bit         mdl_tv [NL];
    int         mdl_rr = 0, mdl_drop = 0, cur_v = 0;
    bit         mdl_ovf = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_obj(input int i, input logic [7:0] x, y, input logic [4:0] pmfa,
                           input logic h, v, input logic [2:0] c);
        obm[i] = '{x: x, y: y, pmfa: pmfa, hflip: h, vflip: v, color: c, rsvd: 6'h2a};
    endtask

    task automatic clear_mem;
        for (int i = 0; i < NOBJ; i++) set_obj(i, 8'd0, 8'd200, 5'd0, 1'b0, 1'b0, 3'd0);
        for (int i = 0; i < 256; i++) pmf[i] = '0;
    endtask

    task automatic opaque(input logic [4:0] pmfa);
        for (int r = 0; r < 8; r++) pmf[{pmfa, 3'(r)}] = 16'hffff;
    endtask

    // Renders line y into model buffer v straight from the object list.
    task automatic model_render(input logic [7:0] y, input int v);
        int cnt;
        logic [7:0] dy, x;
        logic [2:0] r, c;
        logic [15:0] ln;
        logic [1:0] l;
        cnt = 0; mdl_ovf = 0; mdl_drop = 0;
        for (int i = 0; i < 256; i++) mdl_pix[v][i] = '0;
        for (int o = 0; o < NOBJ; o++) begin
            dy = y - obm[o].y;
            if (dy < 8) begin
                if (cnt == MAXL) begin
                    mdl_ovf = 1; mdl_drop++;
                end else begin
                    cnt++;
                    r  = obm[o].vflip ? 3'd7 - dy[2:0] : dy[2:0];
                    ln = pmf[{obm[o].pmfa, r}];
                    for (int k = 0; k < 8; k++) begin
                        c = obm[o].hflip ? 3'(7 - k) : 3'(k);
                        l = ln[15 - 2*c -: 2];
                        x = obm[o].x + 8'(k);
                        if (l != 0 && mdl_pix[v][x] == 0) mdl_pix[v][x] = {l, obm[o].color};
                    end
                end
            end
        end
        mdl_tag[v] = y; mdl_tv[v] = 1;
    endtask

    function automatic logic [4:0] mdl_disp(input logic [7:0] y, x);
        for (int b = 0; b < NL; b++) if (mdl_tv[b] && mdl_tag[b] == y) return mdl_pix[b][x];
        return 5'd0;
    endfunction

    task automatic start_line(input logic [7:0] y);
        @(negedge gpu_clk); prefetch_start_i = 1; prefetch_y_i = y;
        @(negedge gpu_clk); prefetch_start_i = 0;
        chk("busy_after_start", busy_o, 1);
        cur_v = mdl_rr; mdl_rr = (mdl_rr + 1) % NL; mdl_tv[cur_v] = 0;
    endtask

    task automatic finish_line(input logic [7:0] y);
        int n = 0;
        while (done_o !== 1'b1 && n < 4000) begin @(negedge gpu_clk); n++; end
        chk($sformatf("done_seen y=%0d", y), done_o, 1);
        model_render(y, cur_v);
        @(negedge gpu_clk);
        chk("done_single_pulse", done_o, 0);
        chk("busy_idle", busy_o, 0);
        chk($sformatf("overflow y=%0d", y), overflow_o, mdl_ovf);
`ifdef FOREGROUND_LINE_ENGINE_DROPCOUNT_EN
        chk($sformatf("drop_count y=%0d", y), drop_count_o, mdl_drop);
`endif
    endtask

    task automatic do_line(input logic [7:0] y);
        start_line(y);
        finish_line(y);
    endtask

    task automatic check_px(input logic [7:0] y, x, input logic [4:0] exp);
        @(negedge gpu_clk); display_y_i = y; display_x_i = x;
        @(negedge gpu_clk);
        chk($sformatf("pixel y=%0d x=%0d", y, x), pixel_o, exp);
        chk($sformatf("valid y=%0d x=%0d", y, x), valid_o, exp[4:3] != 2'd0);
    endtask

    task automatic check_line(input logic [7:0] y);
        for (int x = 0; x < 256; x++) check_px(y, 8'(x), mdl_disp(y, 8'(x)));
    endtask

    initial begin
        logic [7:0] ty, prev;
        clear_mem;
        #2 rst_n = 0;
        repeat (2) @(negedge gpu_clk);
        chk("rst_busy", busy_o, 0); chk("rst_done", done_o, 0); chk("rst_miss", miss_o, 0);
        chk("rst_ovf", overflow_o, 0); chk("rst_pixel", pixel_o, 0); chk("rst_valid", valid_o, 0);
        chk("rst_obm_addr", obm_addr_o, 0); chk("rst_pmf_addr", pmf_addr_o, 0);
        rst_n = 1;
        // single opaque object
        set_obj(0, 8'd10, 8'd20, 5'd3, 0, 0, 3'b101); opaque(5'd3);
        do_line(8'd23);
        for (int x = 10; x <= 17; x++) check_px(8'd23, 8'(x), 5'b11_101);
        check_px(8'd23, 8'd9, 5'd0); check_px(8'd23, 8'd18, 5'd0);
        chk("ovf_single", overflow_o, 0);
        check_line(8'd23);
        // per-line limit
        clear_mem; opaque(5'd2);
        for (int i = 0; i < 20; i++) set_obj(i, 8'(i * 12), 8'd0, 5'd2, 0, 0, 3'(i));
        do_line(8'd0);
        chk("ovf_limit", overflow_o, 1);
`ifdef FOREGROUND_LINE_ENGINE_DROPCOUNT_EN
        chk("drop_count_4", drop_count_o, 4);
`endif
        check_px(8'd0, 8'd180, 5'b11_111); check_px(8'd0, 8'd192, 5'd0);
        check_line(8'd0);
        // reset in the middle of a draw
        clear_mem; opaque(5'd9); set_obj(5, 8'd30, 8'd9, 5'd9, 0, 0, 3'b111);
        @(negedge gpu_clk); display_y_i = 8'd0; display_x_i = 8'd180;
        start_line(8'd9);
        repeat (17) @(negedge gpu_clk);
        chk("pre_rst_busy", busy_o, 1); chk("pre_rst_obm_addr", obm_addr_o, 5);
        chk("pre_rst_pixel", pixel_o, 5'b11_111);
        rst_n = 0; #1;
        chk("mid_rst_busy", busy_o, 0); chk("mid_rst_ovf", overflow_o, 0);
        chk("mid_rst_pixel", pixel_o, 0); chk("mid_rst_valid", valid_o, 0);
        chk("mid_rst_obm_addr", obm_addr_o, 0); chk("mid_rst_pmf_addr", pmf_addr_o, 0);
        chk("mid_rst_done", done_o, 0);
        for (int b = 0; b < NL; b++) mdl_tv[b] = 0;
        mdl_rr = 0;
        repeat (2) @(negedge gpu_clk);
        rst_n = 1;
        do_line(8'd9);
        check_px(8'd9, 8'd30, 5'b11_111); check_px(8'd9, 8'd29, 5'd0);
        check_line(8'd9);
        // overlap priority and x wrap
        clear_mem; opaque(5'd4);
        set_obj(1, 8'd50, 8'd40, 5'd4, 0, 0, 3'b001);
        set_obj(2, 8'd50, 8'd40, 5'd4, 0, 0, 3'b010);
        set_obj(3, 8'd252, 8'd40, 5'd4, 0, 0, 3'b011);
        do_line(8'd40);
        check_px(8'd40, 8'd50, 5'b11_001); check_px(8'd40, 8'd255, 5'b11_011);
        check_px(8'd40, 8'd3, 5'b11_011); check_px(8'd40, 8'd4, 5'd0);
        check_px(8'd40, 8'd251, 5'd0);
        check_line(8'd40);
        // both flips
        clear_mem; pmf[{5'd7, 3'd0}] = 16'h4000;
        set_obj(0, 8'd100, 8'd60, 5'd7, 1, 1, 3'b110);
        do_line(8'd67);
        check_px(8'd67, 8'd107, 5'b01_110); check_px(8'd67, 8'd100, 5'd0);
        check_line(8'd67);
        // start while busy is dropped
        clear_mem; opaque(5'd1); set_obj(0, 8'd20, 8'd3, 5'd1, 0, 0, 3'b100);
        start_line(8'd5);
        @(negedge gpu_clk);
        chk("miss_idle", miss_o, 0);
        prefetch_start_i = 1; prefetch_y_i = 8'd6;
        @(negedge gpu_clk); prefetch_start_i = 0;
        chk("miss_pulse", miss_o, 1);
        @(negedge gpu_clk);
        chk("miss_clear", miss_o, 0);
        finish_line(8'd5);
        check_px(8'd6, 8'd20, 5'd0); check_px(8'd5, 8'd20, 5'b11_100);
        do_line(8'd6);
        check_px(8'd5, 8'd20, 5'b11_100); check_px(8'd6, 8'd20, 5'b11_100);
        check_line(8'd5); check_line(8'd6);
        // randomized scenes
        prev = 8'd6;
        for (int it = 0; it < 6; it++) begin
            ty = 8'($urandom_range(0, 255));
            for (int i = 0; i < 256; i++) pmf[i] = 16'($urandom);
            for (int o = 0; o < NOBJ; o++) begin
                obm[o] = obm_object_t'($urandom);
                obm[o].y = ty - 8'($urandom_range(0, 13));
            end
            do_line(ty);
            check_line(ty);
            check_line(prev);
            prev = ty;
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
